modelo_persiana: RTL and testbench

MODELO_PERSIANA -- requirements
Module: modelo_persiana

---
 rtl/modelo_persiana.sv | 135 +++++++++++++
 tb/tb_modelo_persiana.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/modelo_persiana.sv
// Blind (roller shutter) plant model: motorised position register with
// prescaled stepping, brake dead-time, fault on conflicting commands.
module modelo_persiana #(
  parameter int ANCHO   = 6,
  parameter int POS_MAX = 40,
  parameter int POS_MED = 20,
  parameter int POS_INI = 0,
  parameter int PRESC   = 4,
  parameter int T_FRENO = 3
) (
  input  logic             Reloj,
  input  logic             reset,
  input  logic             subir,
  input  logic             bajar,
  output logic             Ssup,
  output logic             Smed,
  output logic             Sinf,
  output logic [ANCHO-1:0] posicion,
  output logic             moviendo,
  output logic             falla
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int FW = (T_FRENO > 1) ? $clog2(T_FRENO) : 1;

  localparam logic [ANCHO-1:0] PMAX  = ANCHO'(POS_MAX);
  localparam logic [ANCHO-1:0] PMAX1 = ANCHO'(POS_MAX - 1);
  localparam logic [ANCHO-1:0] PMED  = ANCHO'(POS_MED);
  localparam logic [ANCHO-1:0] PINI  = ANCHO'(POS_INI);
  localparam logic [ANCHO-1:0] UNO   = ANCHO'(1);
  localparam logic [PW-1:0]    PTOP  = PW'(PRESC - 1);
  localparam logic [FW-1:0]    FTOP  = FW'(T_FRENO - 1);

  typedef enum logic [2:0] {
    REPOSO,
    SUBIENDO,
    BAJANDO,
    FRENO,
    FALLA
  } estado_t;

  estado_t        estado;
  logic [PW-1:0]  pres;
  logic [FW-1:0]  freno;

  assign Ssup = (posicion == PMAX);
  assign Smed = (posicion == PMED);
  assign Sinf = (posicion == '0);

  always_ff @(posedge Reloj or negedge reset) begin
    if (!reset) begin
      estado   <= REPOSO;
      posicion <= PINI;
      pres     <= '0;
      freno    <= '0;
      moviendo <= 1'b0;
      falla    <= 1'b0;
    end else if (subir && bajar) begin
      estado   <= FALLA;
      pres     <= '0;
      freno    <= '0;
      moviendo <= 1'b0;
      falla    <= 1'b1;
    end else begin
      case (estado)
        REPOSO: begin
          pres <= '0;
          if (subir && posicion < PMAX) begin
            estado   <= SUBIENDO;
            moviendo <= 1'b1;
          end else if (bajar && posicion != '0) begin
            estado   <= BAJANDO;
            moviendo <= 1'b1;
          end
        end
        SUBIENDO: begin
          if (!subir) begin
            estado   <= FRENO;
            freno    <= '0;
            pres     <= '0;
            moviendo <= 1'b0;
          end else if (pres == PTOP) begin
            pres     <= '0;
            posicion <= posicion + UNO;
            if (posicion == PMAX1) begin
              estado   <= FRENO;
              freno    <= '0;
              moviendo <= 1'b0;
            end
          end else begin
            pres <= pres + 1'b1;
          end
        end
        BAJANDO: begin
          if (!bajar) begin
            estado   <= FRENO;
            freno    <= '0;
            pres     <= '0;
            moviendo <= 1'b0;
          end else if (pres == PTOP) begin
            pres     <= '0;
            posicion <= posicion - UNO;
            if (posicion == UNO) begin
              estado   <= FRENO;
              freno    <= '0;
              moviendo <= 1'b0;
            end
          end else begin
            pres <= pres + 1'b1;
          end
        end
        FRENO: begin
          // dead-time runs regardless of single commands
          if (freno == FTOP) begin
            estado <= REPOSO;
            freno  <= '0;
          end else begin
            freno <= freno + 1'b1;
          end
        end
        FALLA: begin
          estado <= FRENO;
          freno  <= '0;
          falla  <= 1'b0;
        end
        default: begin
          estado   <= REPOSO;
          moviendo <= 1'b0;
          falla    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modelo_persiana.sv
// Randomised + directed bench for modelo_persiana against a
// phase/age reference model.
module tb_modelo_persiana;

  localparam int ANCHO   = 6;
  localparam int POS_MAX = 40;
  localparam int POS_MED = 20;
  localparam int PRESC   = 4;
  localparam int T_FRENO = 3;

  localparam int P_IDLE = 0;
  localparam int P_UP   = 1;
  localparam int P_DN   = 2;
  localparam int P_BRK  = 3;
  localparam int P_FLT  = 4;

  logic             Reloj = 1'b0;
  logic             reset;
  logic             subir;
  logic             bajar;
  logic             Ssup;
  logic             Smed;
  logic             Sinf;
  logic [ANCHO-1:0] posicion;
  logic             moviendo;
  logic             falla;

  int n_vec = 0;
  int n_bad = 0;

  int m_pos;
  int m_ph;
  int m_age;

  modelo_persiana #(
    .ANCHO  (ANCHO),
    .POS_MAX(POS_MAX),
    .POS_MED(POS_MED),
    .POS_INI(0),
    .PRESC  (PRESC),
    .T_FRENO(T_FRENO)
  ) dut (
    .Reloj   (Reloj),
    .reset   (reset),
    .subir   (subir),
    .bajar   (bajar),
    .Ssup    (Ssup),
    .Smed    (Smed),
    .Sinf    (Sinf),
    .posicion(posicion),
    .moviendo(moviendo),
    .falla   (falla)
  );

  always #5 Reloj = ~Reloj;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_ph  = P_IDLE;
    m_age = 0;
  endtask

  // age = edges since the phase was entered; one step per PRESC edges
  task automatic model_edge(input logic s, input logic b);
    if (s && b) begin
      m_ph  = P_FLT;
      m_age = 0;
    end else if (m_ph == P_IDLE) begin
      if (s && m_pos < POS_MAX) begin
        m_ph  = P_UP;
        m_age = 0;
      end else if (b && m_pos > 0) begin
        m_ph  = P_DN;
        m_age = 0;
      end
    end else if (m_ph == P_UP || m_ph == P_DN) begin
      if ((m_ph == P_UP && !s) || (m_ph == P_DN && !b)) begin
        m_ph  = P_BRK;
        m_age = 0;
      end else begin
        m_age++;
        if (m_age % PRESC == 0) begin
          m_pos = m_pos + ((m_ph == P_UP) ? 1 : -1);
          if (m_pos == POS_MAX || m_pos == 0) begin
            m_ph  = P_BRK;
            m_age = 0;
          end
        end
      end
    end else if (m_ph == P_BRK) begin
      m_age++;
      if (m_age == T_FRENO) begin
        m_ph  = P_IDLE;
        m_age = 0;
      end
    end else begin
      m_ph  = P_BRK;
      m_age = 0;
    end
  endtask

  task automatic check_all();
    chk("posicion", 32'(posicion), 32'(m_pos));
    chk("moviendo", 32'(moviendo), 32'(m_ph == P_UP || m_ph == P_DN));
    chk("falla", 32'(falla), 32'(m_ph == P_FLT));
    chk("Ssup", 32'(Ssup), 32'(m_pos == POS_MAX));
    chk("Smed", 32'(Smed), 32'(m_pos == POS_MED));
    chk("Sinf", 32'(Sinf), 32'(m_pos == 0));
  endtask

  task automatic cyc(input logic s, input logic b);
    @(negedge Reloj);
    subir = s;
    bajar = b;
    @(posedge Reloj);
    if (reset) model_edge(s, b);
    else model_reset();
    #1 check_all();
  endtask

  task automatic hold(input logic s, input logic b, input int n);
    for (int i = 0; i < n; i++) cyc(s, b);
  endtask

  // reset pulse asserted between edges; outputs must clear at once
  task automatic async_reset();
    @(negedge Reloj);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_pos", 32'(posicion), 32'd0);
    chk("rst_mov", 32'(moviendo), 32'd0);
    check_all();
    @(posedge Reloj);
    #1 check_all();
    @(negedge Reloj);
    reset = 1'b1;
  endtask

  task automatic go_to(input int target);
    int budget;
    budget = 0;
    while (m_pos != target && budget < 400) begin
      if (m_pos < target) cyc(1'b1, 1'b0);
      else cyc(1'b0, 1'b1);
      budget++;
    end
    chk("go_to", 32'(m_pos), 32'(target));
  endtask

  initial begin
    int saved;
    int sel;
    reset = 1'b0;
    subir = 1'b0;
    bajar = 1'b0;
    model_reset();
    #2;
    chk("ini_pos", 32'(posicion), 32'd0);
    chk("ini_Sinf", 32'(Sinf), 32'd1);
    chk("ini_Smed", 32'(Smed), 32'd0);
    chk("ini_Ssup", 32'(Ssup), 32'd0);
    chk("ini_mov", 32'(moviendo), 32'd0);
    chk("ini_falla", 32'(falla), 32'd0);
    hold(1'b0, 1'b0, 2);
    @(negedge Reloj);
    reset = 1'b1;

    // full travel to the top, keep pushing at the end
    hold(1'b1, 1'b0, 4);
    chk("first_step_pend", 32'(posicion), 32'd0);
    cyc(1'b1, 1'b0);
    chk("first_step", 32'(posicion), 32'd1);
    hold(1'b1, 1'b0, 170);
    chk("top_hold", 32'(posicion), 32'(POS_MAX));
    hold(1'b0, 1'b0, 5);

    // reversal at 10
    go_to(10);
    hold(1'b0, 1'b1, 12);
    hold(1'b0, 1'b0, 5);

    // fault at 12
    go_to(12);
    hold(1'b0, 1'b0, 5);
    cyc(1'b1, 1'b1);
    chk("flt_on", 32'(falla), 32'd1);
    hold(1'b1, 1'b1, 4);
    chk("flt_pos", 32'(posicion), 32'd12);
    hold(1'b0, 1'b0, 6);

    // short pulse discarded
    saved = m_pos;
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 5);
    chk("pulse", 32'(posicion), 32'(saved));

    // reset while moving at 15
    go_to(15);
    cyc(1'b1, 1'b0);
    async_reset();

    // random segments
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 99);
      if (sel < 3) begin
        async_reset();
      end else if (sel < 33) begin
        hold(1'b1, 1'b0, $urandom_range(1, (sel < 10) ? 60 : 14));
      end else if (sel < 63) begin
        hold(1'b0, 1'b1, $urandom_range(1, (sel < 40) ? 60 : 14));
      end else if (sel < 70) begin
        hold(1'b1, 1'b1, $urandom_range(1, 3));
      end else begin
        hold(1'b0, 1'b0, $urandom_range(1, 6));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
